// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcodes, flag positions, FSM states.
// Combinational helpers only; no latency or flow control of its own.
package alu_arb_pkg;

  localparam logic [2:0] OP_PASS_B = 3'b000;
  localparam logic [2:0] OP_ADD    = 3'b010;
  localparam logic [2:0] OP_SUB    = 3'b011;
  localparam logic [2:0] OP_AND    = 3'b100;
  localparam logic [2:0] OP_OR     = 3'b101;
  localparam logic [2:0] OP_XOR    = 3'b110;

  // Bit positions inside resp_flags = {negative, zero, overflow, carry}
  localparam int FLAG_CARRY = 0;
  localparam int FLAG_OVF   = 1;
  localparam int FLAG_ZERO  = 2;
  localparam int FLAG_NEG   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic is_legal_op(input logic [2:0] op);
    return (op == OP_PASS_B) || (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_AND)    || (op == OP_OR)  || (op == OP_XOR);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone requester always wins, contention goes to rr_ptr.
// Purely combinational (zero latency); grant is one-hot or zero.
module rr_arbiter2 (
  input  logic [1:0] req_valid,
  input  logic       rr_ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = rr_ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters; response appears ALU_LAT+1 cycles after accept
// (1 cycle for illegal ops) and is held until the owner asserts resp_ready; no new accept until then.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [2:0]       req_op0,
  input  logic [2:0]       req_op1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_b1,
  output logic [2:0]       alu_cntrl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_negative,
  input  logic             alu_overflow,
  input  logic             alu_carry,
  output logic [1:0]       resp_valid,
  input  logic [1:0]       resp_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic [3:0]       resp_flags,
  output logic             resp_err
);

  localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

  state_e           state_q, state_d;
  logic             rr_ptr_q, rr_ptr_d;
  logic             owner_q, owner_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [2:0]       alu_cntrl_q, alu_cntrl_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [WIDTH-1:0] resp_result_q, resp_result_d;
  logic [3:0]       resp_flags_q, resp_flags_d;
  logic             resp_err_q, resp_err_d;

  logic [1:0]       grant;
  logic             win;
  logic             xfer;
  logic [2:0]       win_op;
  logic [WIDTH-1:0] win_a, win_b;

  rr_arbiter2 u_rr_arbiter2 (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (grant)
  );

  // Gated by reset_n so ready is low while reset is held, even with valid requests present
  always_comb begin
    req_ready = 2'b00;
    if ((state_q == IDLE) && reset_n) req_ready = grant;
  end

  assign xfer   = |(req_valid & req_ready);
  assign win    = grant[1];
  assign win_op = win ? req_op1 : req_op0;
  assign win_a  = win ? req_a1  : req_a0;
  assign win_b  = win ? req_b1  : req_b0;

  assign resp_valid  = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign alu_cntrl   = alu_cntrl_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign resp_result = resp_result_q;
  assign resp_flags  = resp_flags_q;
  assign resp_err    = resp_err_q;

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    owner_d       = owner_q;
    cnt_d         = cnt_q;
    alu_cntrl_d   = alu_cntrl_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    resp_result_d = resp_result_q;
    resp_flags_d  = resp_flags_q;
    resp_err_d    = resp_err_q;

    case (state_q)
      IDLE: begin
        if (xfer) begin
          owner_d = win;
          if (is_legal_op(win_op)) begin
            alu_cntrl_d = win_op;
            alu_a_d     = win_a;
            alu_b_d     = win_b;
            cnt_d       = CNT_INIT;
            state_d     = EXEC;
          end else begin
            // Illegal ops never touch the ALU; answer immediately with an error response
            resp_result_d = '0;
            resp_flags_d  = 4'b0000;
            resp_err_d    = 1'b1;
            state_d       = RESP;
          end
        end
      end
      EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          resp_result_d           = alu_result;
          resp_flags_d[FLAG_NEG]  = alu_negative;
          resp_flags_d[FLAG_ZERO] = alu_zero;
          resp_flags_d[FLAG_OVF]  = alu_overflow;
          resp_flags_d[FLAG_CARRY]= alu_carry;
          resp_err_d              = 1'b0;
          state_d                 = RESP;
        end
      end
      RESP: begin
        if (resp_ready[owner_q]) begin
          state_d  = IDLE;
          rr_ptr_d = ~owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      rr_ptr_q      <= 1'b0;
      owner_q       <= 1'b0;
      cnt_q         <= 4'd0;
      alu_cntrl_q   <= 3'b000;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      resp_result_q <= '0;
      resp_flags_q  <= 4'b0000;
      resp_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      owner_q       <= owner_d;
      cnt_q         <= cnt_d;
      alu_cntrl_q   <= alu_cntrl_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      resp_result_q <= resp_result_d;
      resp_flags_q  <= resp_flags_d;
      resp_err_q    <= resp_err_d;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU environment plus a spec-level reference model
// (round-robin pointer, opcode arithmetic, response latency) driven with random requests.
module tb_alu_arbiter;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  req_valid, req_ready, resp_valid, resp_ready;
  logic [2:0]  req_op0, req_op1, alu_cntrl;
  logic [63:0] req_a0, req_a1, req_b0, req_b1, alu_a, alu_b, alu_result, resp_result;
  logic        alu_zero, alu_negative, alu_overflow, alu_carry, resp_err;
  logic [3:0]  resp_flags;
  logic [67:0] alu_env;

  int n_checks = 0;
  int n_pass   = 0;
  int cycle_cnt = 0;
  logic model_ptr;
  logic [2:0] legal_ops [6] = '{3'b000, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110};

  alu_arbiter #(.WIDTH(64), .ALU_LAT(LAT)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .alu_cntrl(alu_cntrl), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_negative(alu_negative),
    .alu_overflow(alu_overflow), .alu_carry(alu_carry),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_flags(resp_flags), .resp_err(resp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // Returns {negative, zero, overflow, carry, result}; illegal opcodes give all zeros
  function automatic logic [67:0] ref_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [64:0] s;
    logic [63:0] r;
    logic c, v;
    r = '0; c = 1'b0; v = 1'b0; s = '0;
    case (op)
      3'b000: r = b;
      3'b010: begin s = {1'b0, a} + {1'b0, b}; r = s[63:0]; c = s[64]; v = (a[63] == b[63]) && (r[63] != a[63]); end
      3'b011: begin r = a - b; c = (a < b); v = (a[63] != b[63]) && (r[63] != a[63]); end
      3'b100: r = a & b;
      3'b101: r = a | b;
      3'b110: r = a ^ b;
      default: return 68'd0;
    endcase
    return {r[63], (r == 64'd0), v, c, r};
  endfunction

  function automatic logic ref_legal(input logic [2:0] op);
    return (op != 3'b001) && (op != 3'b111);
  endfunction

  function automatic logic [1:0] ref_grant(input logic [1:0] v, input logic ptr);
    if (v == 2'b11) return ptr ? 2'b10 : 2'b01;
    return v;
  endfunction

  always_comb begin
    alu_env = ref_op(alu_cntrl, alu_a, alu_b);
    alu_result = alu_env[63:0];
    {alu_negative, alu_zero, alu_overflow, alu_carry} = alu_env[67:64];
  end

  task automatic wait_grant(output logic [1:0] g, output int gcyc);
    g = 2'b00; gcyc = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        g = req_ready; gcyc = cycle_cnt;
        @(posedge clk); #1;
        return;
      end
    end
  endtask

  // lat counts cycles from the transfer cycle
  task automatic wait_resp(output int lat, output logic [1:0] v, output logic [63:0] r,
                           output logic [3:0] f, output logic e);
    lat = -1; v = 2'b00; r = '0; f = 4'b0; e = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (resp_valid != 2'b00) begin
        lat = i; v = resp_valid; r = resp_result; f = resp_flags; e = resp_err;
        return;
      end
    end
  endtask

  task automatic accept(input logic [1:0] bits);
    resp_ready = bits;
    @(posedge clk); #1;
    resp_ready = 2'b00;
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    model_ptr = 1'b0;
  endtask

  task automatic test_reset;
    req_valid = 2'b11; resp_ready = 2'b00;
    req_op0 = 3'b010; req_op1 = 3'b011;
    req_a0 = 64'd1; req_a1 = 64'd2; req_b0 = 64'd3; req_b1 = 64'd4;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if ({alu_cntrl, alu_a, alu_b} !== 131'd0) $display("FAIL reset_alu_regs got %h/%h/%h exp 0", alu_cntrl, alu_a, alu_b); else n_pass++;
    n_checks++; if (req_ready !== 2'b00) $display("FAIL reset_req_ready got %b exp 00", req_ready); else n_pass++;
    n_checks++; if (resp_valid !== 2'b00) $display("FAIL reset_resp_valid got %b exp 00", resp_valid); else n_pass++;
    n_checks++; if ({resp_result, resp_flags, resp_err} !== 69'd0) $display("FAIL reset_resp_regs got %h/%b/%b exp 0", resp_result, resp_flags, resp_err); else n_pass++;
    req_valid = 2'b00;
    reset_n = 1'b1;
    model_ptr = 1'b0;
  endtask

  task automatic test_single;
    logic [1:0] g, v; int gc, lat; logic [63:0] r; logic [3:0] f; logic e;
    req_valid = 2'b01; req_op0 = 3'b010; req_a0 = 64'd10; req_b0 = 64'd100;
    wait_grant(g, gc);
    req_valid = 2'b00;
    n_checks++; if (g !== 2'b01) $display("FAIL single_grant got %b exp 01", g); else n_pass++;
    wait_resp(lat, v, r, f, e);
    n_checks++; if (lat !== 1 + LAT) $display("FAIL single_latency got %0d exp %0d", lat, 1 + LAT); else n_pass++;
    n_checks++; if (v !== 2'b01) $display("FAIL single_resp_valid got %b exp 01", v); else n_pass++;
    n_checks++; if ({r, f, e} !== {64'd110, 4'b0000, 1'b0}) $display("FAIL single_resp got %0d/%b/%b exp 110/0000/0", r, f, e); else n_pass++;
    accept(2'b01);
    model_ptr = 1'b1;
  endtask

  task automatic test_contention;
    logic [1:0] g, v; int gc, lat; logic [63:0] r; logic [3:0] f; logic e;
    do_reset();
    req_valid = 2'b11;
    req_op0 = 3'b011; req_a0 = 64'd64; req_b0 = 64'd64;
    req_op1 = 3'b110; req_a1 = 64'hFF; req_b1 = 64'h0F;
    wait_grant(g, gc);
    n_checks++; if (g !== 2'b01) $display("FAIL cont_first_grant got %b exp 01", g); else n_pass++;
    req_op0 = 3'b100; req_a0 = 64'hF0F0; req_b0 = 64'hFF00;
    wait_resp(lat, v, r, f, e);
    n_checks++; if ({v, r, f, e} !== {2'b01, 64'd0, 4'b0100, 1'b0}) $display("FAIL cont_sub got %b/%h/%b/%b exp 01/0/0100/0", v, r, f, e); else n_pass++;
    accept(2'b01);
    wait_grant(g, gc);
    n_checks++; if (g !== 2'b10) $display("FAIL cont_second_grant got %b exp 10", g); else n_pass++;
    req_op1 = 3'b101; req_a1 = 64'h1; req_b1 = 64'h2;
    wait_resp(lat, v, r, f, e);
    n_checks++; if ({v, r, f, e} !== {2'b10, 64'hF0, 4'b0000, 1'b0}) $display("FAIL cont_xor got %b/%h/%b/%b exp 10/f0/0000/0", v, r, f, e); else n_pass++;
    accept(2'b10);
    wait_grant(g, gc);
    n_checks++; if (g !== 2'b01) $display("FAIL cont_ptr_back_to_0 got %b exp 01", g); else n_pass++;
    req_valid = 2'b10;
    wait_resp(lat, v, r, f, e);
    n_checks++; if ({v, r} !== {2'b01, 64'hF000}) $display("FAIL cont_and got %b/%h exp 01/f000", v, r); else n_pass++;
    accept(2'b01);
    model_ptr = 1'b1;
    wait_grant(g, gc);
    req_valid = 2'b00;
    wait_resp(lat, v, r, f, e);
    accept(g);
    model_ptr = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [1:0] g, v, eg; int gc, prev, lat; logic [63:0] r; logic [3:0] f; logic e; logic [67:0] exp;
    prev = 0;
    req_valid = 2'b11;
    req_op0 = legal_ops[$urandom_range(0, 5)]; req_a0 = {$urandom, $urandom}; req_b0 = {$urandom, $urandom};
    req_op1 = legal_ops[$urandom_range(0, 5)]; req_a1 = {$urandom, $urandom}; req_b1 = {$urandom, $urandom};
    for (int k = 0; k < 4; k++) begin
      eg = ref_grant(2'b11, model_ptr);
      exp = eg[1] ? ref_op(req_op1, req_a1, req_b1) : ref_op(req_op0, req_a0, req_b0);
      wait_grant(g, gc);
      n_checks++; if (g !== eg) $display("FAIL b2b_grant%0d got %b exp %b", k, g, eg); else n_pass++;
      if (k > 0) begin
        n_checks++; if (gc - prev !== 2 + LAT) $display("FAIL b2b_spacing%0d got %0d exp %0d", k, gc - prev, 2 + LAT); else n_pass++;
      end
      prev = gc;
      if (eg[1]) begin req_op1 = legal_ops[$urandom_range(0, 5)]; req_a1 = {$urandom, $urandom}; req_b1 = {$urandom, $urandom}; end
      else begin req_op0 = legal_ops[$urandom_range(0, 5)]; req_a0 = {$urandom, $urandom}; req_b0 = {$urandom, $urandom}; end
      wait_resp(lat, v, r, f, e);
      n_checks++; if ({v, f, r} !== {eg, exp}) $display("FAIL b2b_resp%0d got %b/%b/%h exp %b/%b/%h", k, v, f, r, eg, exp[67:64], exp[63:0]); else n_pass++;
      accept(eg);
      model_ptr = ~eg[1];
    end
    req_valid = 2'b00;
  endtask

  task automatic test_illegal;
    logic [1:0] g, v; int gc, lat; logic [63:0] r, sa; logic [3:0] f; logic e; logic [2:0] sc;
    sc = alu_cntrl; sa = alu_a;
    req_valid = 2'b10; req_op1 = 3'b111; req_a1 = {$urandom, $urandom}; req_b1 = {$urandom, $urandom};
    wait_grant(g, gc);
    req_valid = 2'b00;
    n_checks++; if (g !== 2'b10) $display("FAIL illegal_grant got %b exp 10", g); else n_pass++;
    wait_resp(lat, v, r, f, e);
    n_checks++; if (lat !== 1) $display("FAIL illegal_latency got %0d exp 1", lat); else n_pass++;
    n_checks++; if ({v, r, f, e} !== {2'b10, 64'd0, 4'b0000, 1'b1}) $display("FAIL illegal_resp got %b/%h/%b/%b exp 10/0/0000/1", v, r, f, e); else n_pass++;
    n_checks++; if ({alu_cntrl, alu_a} !== {sc, sa}) $display("FAIL illegal_alu_hold got %b/%h exp %b/%h", alu_cntrl, alu_a, sc, sa); else n_pass++;
    accept(2'b10);
    model_ptr = 1'b0;
  endtask

  task automatic test_backpressure;
    logic [1:0] g, v; int gc, lat, rc; logic [63:0] r; logic [3:0] f; logic e; logic [67:0] exp; int bad;
    req_valid = 2'b01; req_op0 = legal_ops[$urandom_range(0, 5)]; req_a0 = {$urandom, $urandom}; req_b0 = {$urandom, $urandom};
    exp = ref_op(req_op0, req_a0, req_b0);
    wait_grant(g, gc);
    req_valid = 2'b10; req_op1 = legal_ops[$urandom_range(0, 5)]; req_a1 = {$urandom, $urandom}; req_b1 = {$urandom, $urandom};
    wait_resp(lat, v, r, f, e);
    n_checks++; if ({v, r} !== {2'b01, exp[63:0]}) $display("FAIL bp_resp got %b/%h exp 01/%h", v, r, exp[63:0]); else n_pass++;
    resp_ready = 2'b10;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (resp_valid !== 2'b01 || resp_result !== exp[63:0] || req_ready !== 2'b00) bad++;
    end
    n_checks++; if (bad !== 0) $display("FAIL bp_hold got %0d bad cycles exp 0", bad); else n_pass++;
    n_checks++; if (req_ready !== 2'b00) $display("FAIL bp_release_ready got %b exp 00", req_ready); else n_pass++;
    rc = cycle_cnt;
    exp = ref_op(req_op1, req_a1, req_b1);
    accept(2'b01);
    model_ptr = 1'b1;
    wait_grant(g, gc);
    req_valid = 2'b00;
    n_checks++; if ({g, gc} !== {2'b10, rc + 1}) $display("FAIL bp_next_grant got %b@%0d exp 10@%0d", g, gc, rc + 1); else n_pass++;
    wait_resp(lat, v, r, f, e);
    n_checks++; if ({v, f, r} !== {2'b10, exp}) $display("FAIL bp_second_resp got %b/%b/%h exp 10/%b/%h", v, f, r, exp[67:64], exp[63:0]); else n_pass++;
    accept(2'b10);
    model_ptr = 1'b0;
  endtask

  task automatic test_reset_mid_exec;
    logic [1:0] g, v; int gc, lat, seen; logic [63:0] r; logic [3:0] f; logic e; logic [67:0] exp;
    req_valid = 2'b01; req_op0 = 3'b101; req_a0 = {$urandom, $urandom} | 64'h1; req_b0 = 64'h8000;
    wait_grant(g, gc);
    req_valid = 2'b00;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    n_checks++; if ({alu_cntrl, alu_a, alu_b} !== 131'd0) $display("FAIL midrst_alu_regs got %b/%h/%h exp 0", alu_cntrl, alu_a, alu_b); else n_pass++;
    n_checks++; if ({req_ready, resp_valid, resp_result, resp_flags, resp_err} !== 73'd0) $display("FAIL midrst_outputs got %b/%b/%h/%b/%b exp 0", req_ready, resp_valid, resp_result, resp_flags, resp_err); else n_pass++;
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_ptr = 1'b0;
    seen = 0;
    for (int i = 0; i < LAT + 4; i++) begin
      @(negedge clk);
      if (resp_valid !== 2'b00) seen++;
    end
    n_checks++; if (seen !== 0) $display("FAIL midrst_no_resp got %0d cycles exp 0", seen); else n_pass++;
    @(posedge clk); #1;
    req_valid = 2'b10; req_op1 = 3'b010; req_a1 = {$urandom, $urandom}; req_b1 = {$urandom, $urandom};
    exp = ref_op(req_op1, req_a1, req_b1);
    wait_grant(g, gc);
    req_valid = 2'b00;
    n_checks++; if (g !== 2'b10) $display("FAIL midrst_regrant got %b exp 10", g); else n_pass++;
    wait_resp(lat, v, r, f, e);
    n_checks++; if ({lat, v, f, r} !== {1 + LAT, 2'b10, exp}) $display("FAIL midrst_resp got %0d/%b/%b/%h exp %0d/10/%b/%h", lat, v, f, r, 1 + LAT, exp[67:64], exp[63:0]); else n_pass++;
    accept(2'b10);
    model_ptr = 1'b0;
  endtask

  task automatic test_random;
    logic [1:0] g, v, vld, eg; int gc, lat, elat; logic [63:0] r; logic [3:0] f; logic e, legal; logic [67:0] exp; logic [2:0] op;
    for (int k = 0; k < 24; k++) begin
      vld = 2'($urandom_range(1, 3));
      req_op0 = 3'($urandom_range(0, 7)); req_a0 = {$urandom, $urandom}; req_b0 = {$urandom, $urandom};
      req_op1 = 3'($urandom_range(0, 7)); req_a1 = {$urandom, $urandom}; req_b1 = {$urandom, $urandom};
      if (k % 4 == 0) req_b0 = req_a0;
      req_valid = vld;
      eg = ref_grant(vld, model_ptr);
      op = eg[1] ? req_op1 : req_op0;
      legal = ref_legal(op);
      exp = eg[1] ? ref_op(req_op1, req_a1, req_b1) : ref_op(req_op0, req_a0, req_b0);
      elat = legal ? 1 + LAT : 1;
      wait_grant(g, gc);
      req_valid = 2'b00;
      n_checks++; if (g !== eg) $display("FAIL rand_grant%0d got %b exp %b", k, g, eg); else n_pass++;
      wait_resp(lat, v, r, f, e);
      n_checks++; if ({lat, v, e} !== {elat, eg, ~legal}) $display("FAIL rand_ctrl%0d got lat%0d/%b/%b exp lat%0d/%b/%b", k, lat, v, e, elat, eg, ~legal); else n_pass++;
      n_checks++; if ({f, r} !== exp) $display("FAIL rand_data%0d got %b/%h exp %b/%h", k, f, r, exp[67:64], exp[63:0]); else n_pass++;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      accept(eg);
      model_ptr = ~eg[1];
    end
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 2'b00; resp_ready = 2'b00;
    req_op0 = '0; req_op1 = '0; req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0;
    model_ptr = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_illegal();
    test_backpressure();
    test_reset_mid_exec();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout got no completion exp completion");
    $fatal(1, "watchdog");
  end

endmodule
